// File: rtl/io_cmd_pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_cmd_pipeline_pkg
// Purpose  : Shared widths, defaults and the command-slot type for the
//            io_cmd_pipeline block.
// Revision : 1.0
// ============================================================================
package io_cmd_pipeline_pkg;

  localparam int          ADDR_W              = 5;
  localparam int          DATA_W              = 32;
  localparam int          BE_W                = 4;
  localparam int          MAX_PENDING_DEFAULT = 8;
  localparam logic [31:0] ERR_DATA_DEFAULT    = 32'hDEADBEEF;

  // Width of a counter that must hold the values 0..max_count inclusive.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

  localparam int CNT_W = cnt_width(MAX_PENDING_DEFAULT);

  typedef struct packed {
    logic              is_read;
    logic              is_write;
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic [DATA_W-1:0] writedata;
  } cmd_t;

endpackage
`default_nettype wire

// File: rtl/io_cmd_pipeline_if.sv
`default_nettype none
// ============================================================================
// Module   : io_cmd_pipeline_if
// Purpose  : Word-addressed memory-mapped bus with waitrequest and pipelined
//            read responses.
// Revision : 1.0
// ============================================================================
interface io_cmd_pipeline_if;
  import io_cmd_pipeline_pkg::*;

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );

endinterface
`default_nettype wire

// File: rtl/io_read_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : io_read_watchdog
// Purpose  : Tracks outstanding reads, synthesizes a response for reads that
//            never return, and filters late or stray responses.
// Revision : 1.0
// ============================================================================
module io_read_watchdog
  import io_cmd_pipeline_pkg::*;
#(
  parameter int MAX_PENDING    = MAX_PENDING_DEFAULT,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                               slave_clk,
  input  logic                               slave_reset_n,
  input  logic                               read_issued,
  input  logic                               rsp_valid,
  output logic [cnt_width(MAX_PENDING)-1:0]  pending,
  output logic [cnt_width(MAX_PENDING)-1:0]  dropped,
  output logic                               room,
  output logic                               synth_resp,
  output logic                               forward_resp
);

  localparam int                   c_cw      = cnt_width(MAX_PENDING);
  localparam int                   c_tw      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_tw-1:0]      c_tmax    = c_tw'(TIMEOUT_CYCLES - 1);
  localparam logic [c_cw:0]        c_max_out = (c_cw + 1)'(MAX_PENDING);

  logic [c_cw-1:0] r_pending;
  logic [c_cw-1:0] r_dropped;
  logic [c_tw-1:0] r_timer;

  logic            w_any_pending;
  logic            w_has_dropped;
  logic            w_discard;
  logic [c_cw:0]   w_outstanding;

  assign w_any_pending = (r_pending != '0);
  assign w_has_dropped = (r_dropped != '0);

  // Late responses for timed-out reads come back first, so they are eaten
  // before anything is forwarded; a response with nothing pending is stray.
  assign forward_resp  = rsp_valid & ~w_has_dropped & w_any_pending;
  assign w_discard     = rsp_valid & w_has_dropped;
  assign synth_resp    = w_any_pending & ~rsp_valid & (r_timer == c_tmax);

  assign w_outstanding = {1'b0, r_pending} + {1'b0, r_dropped};
  assign room          = (w_outstanding < c_max_out);

  assign pending       = r_pending;
  assign dropped       = r_dropped;

  always_ff @(posedge slave_clk or negedge slave_reset_n) begin
    if (!slave_reset_n) begin
      r_pending <= '0;
      r_dropped <= '0;
      r_timer   <= '0;
    end else begin
      case ({read_issued, forward_resp | synth_resp})
        2'b10:   r_pending <= r_pending + c_cw'(1);
        2'b01:   r_pending <= r_pending - c_cw'(1);
        default: r_pending <= r_pending;
      endcase

      // A timeout moves one read from pending to dropped, so the sum stays
      // bounded by the issue gate and neither counter can wrap.
      if (synth_resp)
        r_dropped <= r_dropped + c_cw'(1);
      else if (w_discard)
        r_dropped <= r_dropped - c_cw'(1);

      if (!w_any_pending || rsp_valid || synth_resp)
        r_timer <= '0;
      else
        r_timer <= r_timer + c_tw'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/io_cmd_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : io_cmd_pipeline
// Purpose  : Single-slot command pipeline from a CPU port to a crossing port,
//            with outstanding-read limiting and a read-response watchdog.
// Revision : 1.0
// ============================================================================
module io_cmd_pipeline
  import io_cmd_pipeline_pkg::*;
#(
  parameter int                MAX_PENDING    = MAX_PENDING_DEFAULT,
  parameter int                TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic                              slave_clk,
  input  logic                              slave_reset_n,
  io_cmd_pipeline_if.slave                  cpu,
  io_cmd_pipeline_if.master                 xb,
  input  logic                              timeout_clr,
  output logic                              timeout_flag,
  output logic [cnt_width(MAX_PENDING)-1:0] pending_count
);

  localparam int c_cw = cnt_width(MAX_PENDING);

  cmd_t              r_cmd;
  logic              r_cmd_valid;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_timeout_flag;

  logic              w_issue;
  logic              w_capture;
  logic              w_read_issued;
  logic              w_room;
  logic              w_synth;
  logic              w_forward;
  logic [c_cw-1:0]   w_pending;
  logic [c_cw-1:0]   w_dropped;

  // The slot frees in the same cycle it issues, so a new command can be
  // accepted back-to-back without a bubble.
  assign w_issue         = (xb.read | xb.write) & ~xb.waitrequest;
  assign cpu.waitrequest = r_cmd_valid & ~w_issue;
  assign w_capture       = (cpu.read | cpu.write) & ~cpu.waitrequest;

  assign xb.write        = r_cmd_valid & r_cmd.is_write;
  assign xb.read         = r_cmd_valid & r_cmd.is_read & w_room;
  assign xb.address      = r_cmd.address;
  assign xb.byteenable   = r_cmd.byteenable;
  assign xb.writedata    = r_cmd.writedata;
  assign w_read_issued   = xb.read & ~xb.waitrequest;

  assign cpu.readdata      = r_rsp_data;
  assign cpu.readdatavalid = r_rsp_valid;
  assign timeout_flag      = r_timeout_flag;
  assign pending_count     = w_pending;

  always_ff @(posedge slave_clk or negedge slave_reset_n) begin
    if (!slave_reset_n) begin
      r_cmd_valid <= 1'b0;
      r_cmd       <= '0;
    end else if (w_capture) begin
      r_cmd_valid      <= 1'b1;
      // Read and write together is illegal; resolve it as a read.
      r_cmd.is_read    <= cpu.read;
      r_cmd.is_write   <= cpu.write & ~cpu.read;
      r_cmd.address    <= cpu.address;
      r_cmd.byteenable <= cpu.byteenable;
      r_cmd.writedata  <= cpu.writedata;
    end else if (w_issue) begin
      r_cmd_valid <= 1'b0;
    end
  end

  io_read_watchdog #(
    .MAX_PENDING    (MAX_PENDING),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .slave_clk     (slave_clk),
    .slave_reset_n (slave_reset_n),
    .read_issued   (w_read_issued),
    .rsp_valid     (xb.readdatavalid),
    .pending       (w_pending),
    .dropped       (w_dropped),
    .room          (w_room),
    .synth_resp    (w_synth),
    .forward_resp  (w_forward)
  );

  always_ff @(posedge slave_clk or negedge slave_reset_n) begin
    if (!slave_reset_n) begin
      r_rsp_valid    <= 1'b0;
      r_rsp_data     <= '0;
      r_timeout_flag <= 1'b0;
    end else begin
      r_rsp_valid <= w_forward | w_synth;
      if (w_forward)
        r_rsp_data <= xb.readdata;
      else if (w_synth)
        r_rsp_data <= ERR_DATA;

      if (w_synth)
        r_timeout_flag <= 1'b1;
      else if (timeout_clr)
        r_timeout_flag <= 1'b0;
    end
  end

  // The dropped count only feeds the issue gate inside the watchdog.
  logic w_unused;
  assign w_unused = ^w_dropped;

endmodule
`default_nettype wire

// File: tb/tb_io_cmd_pipeline.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_io_cmd_pipeline
// Purpose  : Directed self-checking bench for io_cmd_pipeline.
// Revision : 1.0
// ============================================================================
module tb_io_cmd_pipeline;
  import io_cmd_pipeline_pkg::*;

  logic       slave_clk = 1'b0;
  logic       slave_reset_n;
  logic       timeout_clr;
  logic       timeout_flag;
  logic [3:0] pending_count;

  int n_checks = 0;
  int n_errors = 0;

  io_cmd_pipeline_if cpu_bus ();
  io_cmd_pipeline_if xb_bus ();

  io_cmd_pipeline dut (
    .slave_clk     (slave_clk),
    .slave_reset_n (slave_reset_n),
    .cpu           (cpu_bus),
    .xb            (xb_bus),
    .timeout_clr   (timeout_clr),
    .timeout_flag  (timeout_flag),
    .pending_count (pending_count)
  );

  always #5 slave_clk = ~slave_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge slave_clk);
      #1;
    end
  endtask

  task automatic cpu_cmd(input logic rd, input logic wr, input logic [4:0] a, input logic [31:0] d);
    cpu_bus.read       = rd;
    cpu_bus.write      = wr;
    cpu_bus.address    = a;
    cpu_bus.byteenable = 4'hF;
    cpu_bus.writedata  = d;
  endtask

  task automatic cpu_idle();
    cpu_cmd(1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic xb_rsp(input logic v, input logic [31:0] d);
    xb_bus.readdatavalid = v;
    xb_bus.readdata      = d;
  endtask

  initial begin
    slave_reset_n      = 1'b0;
    timeout_clr        = 1'b0;
    xb_bus.waitrequest = 1'b0;
    cpu_idle();
    xb_rsp(1'b0, 32'd0);
    step(3);

    // Reset state
    chk("rst_pending", 32'(pending_count), 0);
    chk("rst_rdv",     32'(cpu_bus.readdatavalid), 0);
    chk("rst_wait",    32'(cpu_bus.waitrequest), 0);
    chk("rst_xb_rw",   32'({xb_bus.read, xb_bus.write}), 0);
    chk("rst_xb_addr", 32'(xb_bus.address), 0);
    chk("rst_xb_wd",   xb_bus.writedata, 0);
    chk("rst_rdata",   cpu_bus.readdata, 0);
    chk("rst_flag",    32'(timeout_flag), 0);
    slave_reset_n = 1'b1;
    step();

    // Posted write
    cpu_cmd(1'b0, 1'b1, 5'd3, 32'h12345678);
    #1 chk("wr_accept", 32'(cpu_bus.waitrequest), 0);
    step();
    cpu_idle();
    #1;
    chk("wr_xb_write", 32'(xb_bus.write), 1);
    chk("wr_xb_read",  32'(xb_bus.read), 0);
    chk("wr_xb_addr",  32'(xb_bus.address), 3);
    chk("wr_xb_data",  xb_bus.writedata, 32'h12345678);
    step();
    chk("wr_done",     32'(xb_bus.write), 0);
    chk("wr_no_rdv",   32'(cpu_bus.readdatavalid), 0);

    // Write stalled by the crossing holds the slot stable
    xb_bus.waitrequest = 1'b1;
    cpu_cmd(1'b0, 1'b1, 5'd7, 32'h0BADF00D);
    step();
    cpu_idle();
    #1;
    chk("stall_wait",  32'(cpu_bus.waitrequest), 1);
    step(2);
    chk("stall_write", 32'(xb_bus.write), 1);
    chk("stall_addr",  32'(xb_bus.address), 7);
    chk("stall_data",  xb_bus.writedata, 32'h0BADF00D);
    xb_bus.waitrequest = 1'b0;
    #1 chk("stall_rel", 32'(cpu_bus.waitrequest), 0);
    step();
    chk("stall_done",  32'(xb_bus.write), 0);

    // Single read, response 10 cycles later
    cpu_cmd(1'b1, 1'b0, 5'd5, 32'd0);
    step();
    cpu_idle();
    #1;
    chk("rd_xb_read",  32'(xb_bus.read), 1);
    chk("rd_xb_addr",  32'(xb_bus.address), 5);
    step();
    chk("rd_pend1",    32'(pending_count), 1);
    step(9);
    xb_rsp(1'b1, 32'hCAFE0001);
    step();
    xb_rsp(1'b0, 32'd0);
    chk("rd_rdv",      32'(cpu_bus.readdatavalid), 1);
    chk("rd_data",     cpu_bus.readdata, 32'hCAFE0001);
    chk("rd_pend0",    32'(pending_count), 0);
    step();
    chk("rd_rdv_off",  32'(cpu_bus.readdatavalid), 0);

    // Read and write together resolves to a read
    cpu_cmd(1'b1, 1'b1, 5'd9, 32'h55);
    step();
    cpu_idle();
    #1;
    chk("both_rw", 32'({xb_bus.read, xb_bus.write}), 32'b10);
    step();
    chk("both_pend", 32'(pending_count), 1);
    xb_rsp(1'b1, 32'h00000009);
    step();
    xb_rsp(1'b0, 32'd0);
    chk("both_data", cpu_bus.readdata, 32'h00000009);

    // Nine reads with no responses: the ninth waits in the slot
    for (int i = 0; i < 9; i++) begin
      cpu_cmd(1'b1, 1'b0, 5'(i), 32'd0);
      #1 chk("lim_accept", 32'(cpu_bus.waitrequest), 0);
      step();
    end
    cpu_idle();
    #1;
    chk("lim_pend8", 32'(pending_count), 8);
    chk("lim_noread", 32'(xb_bus.read), 0);
    chk("lim_wait",  32'(cpu_bus.waitrequest), 1);
    step(4);
    chk("lim_hold",  32'(cpu_bus.waitrequest), 1);
    xb_rsp(1'b1, 32'hA0);
    step();
    xb_rsp(1'b0, 32'd0);
    chk("lim_rsp",   cpu_bus.readdata, 32'hA0);
    chk("lim_pend7", 32'(pending_count), 7);
    #1;
    chk("lim_issue", 32'(xb_bus.read), 1);
    chk("lim_addr8", 32'(xb_bus.address), 8);
    step();
    chk("lim_refill", 32'(pending_count), 8);
    for (int i = 0; i < 8; i++) begin
      xb_rsp(1'b1, 32'hB0 + 32'(i));
      step();
      chk("lim_drain", cpu_bus.readdata, 32'hB0 + 32'(i));
    end
    xb_rsp(1'b0, 32'd0);
    chk("lim_empty", 32'(pending_count), 0);

    // Timeout, with clear coincident with the flag being set
    cpu_cmd(1'b1, 1'b0, 5'd1, 32'd0);
    step();
    cpu_idle();
    step();
    chk("to_pend1", 32'(pending_count), 1);
    step(1022);
    chk("to_early", 32'(cpu_bus.readdatavalid), 0);
    step();
    chk("to_last",  32'(cpu_bus.readdatavalid), 0);
    timeout_clr = 1'b1;
    step();
    timeout_clr = 1'b0;
    chk("to_rdv",   32'(cpu_bus.readdatavalid), 1);
    chk("to_data",  cpu_bus.readdata, 32'hDEADBEEF);
    chk("to_flag",  32'(timeout_flag), 1);
    chk("to_pend0", 32'(pending_count), 0);
    chk("to_drop1", 32'(dut.u_watchdog.r_dropped), 1);
    step(75);
    xb_rsp(1'b1, 32'hFEED1100);
    step();
    xb_rsp(1'b0, 32'd0);
    chk("late_drop0", 32'(dut.u_watchdog.r_dropped), 0);
    chk("late_norv",  32'(cpu_bus.readdatavalid), 0);
    chk("late_pend",  32'(pending_count), 0);
    timeout_clr = 1'b1;
    step();
    timeout_clr = 1'b0;
    chk("clr_flag",   32'(timeout_flag), 0);

    // Real response exactly in the timeout cycle wins
    cpu_cmd(1'b1, 1'b0, 5'd2, 32'd0);
    step();
    cpu_idle();
    step();
    step(1023);
    xb_rsp(1'b1, 32'h5A5A0034);
    step();
    xb_rsp(1'b0, 32'd0);
    chk("race_rdv",   32'(cpu_bus.readdatavalid), 1);
    chk("race_data",  cpu_bus.readdata, 32'h5A5A0034);
    chk("race_flag",  32'(timeout_flag), 0);
    chk("race_drop",  32'(dut.u_watchdog.r_dropped), 0);
    chk("race_pend",  32'(pending_count), 0);
    step();
    chk("race_quiet", 32'(cpu_bus.readdatavalid), 0);

    // Mid-operation reset with three reads outstanding
    for (int i = 0; i < 3; i++) begin
      cpu_cmd(1'b1, 1'b0, 5'(16 + i), 32'd0);
      step();
    end
    cpu_idle();
    step();
    chk("mrst_pend3", 32'(pending_count), 3);
    #2 slave_reset_n = 1'b0;
    #1;
    chk("mrst_pend",  32'(pending_count), 0);
    chk("mrst_drop",  32'(dut.u_watchdog.r_dropped), 0);
    chk("mrst_xb",    32'({xb_bus.read, cpu_bus.waitrequest}), 0);
    step(2);
    slave_reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      xb_rsp(1'b1, 32'h77);
      step();
      chk("stray_norv", 32'(cpu_bus.readdatavalid), 0);
    end
    xb_rsp(1'b0, 32'd0);
    chk("stray_pend", 32'(pending_count), 0);
    chk("stray_drop", 32'(dut.u_watchdog.r_dropped), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/io_cmd_pipeline.md
IO_CMD_PIPELINE -- requirements
Module: io_cmd_pipeline

Interface
REQ-001 SHALL have parameter MAX_PENDING, default 8: maximum reads outstanding toward the crossing, counting CPU-visible and dropped reads.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: cycles a read may wait before an error response is synthesized.
REQ-003 SHALL have parameter ERR_DATA, default 32'hDEADBEEF: readdata returned on a synthesized response.
REQ-004 slave_clk  in  1  clock; all logic in this domain.
REQ-005 slave_reset_n  in  1  reset, asynchronous, active-low.
REQ-006 cpu_address  in  5  word address; cpu_byteenable in 4; cpu_read in 1; cpu_write in 1; cpu_writedata in 32.
REQ-007 cpu_waitrequest  out  1; cpu_readdata  out  32; cpu_readdatavalid  out  1.
REQ-008 xb_address  out  5; xb_byteenable  out  4; xb_read  out  1; xb_write  out  1; xb_writedata  out  32 (to crossing slave port).
REQ-009 xb_waitrequest  in  1; xb_readdata  in  32; xb_readdatavalid  in  1 (from crossing slave port).
REQ-010 timeout_clr  in  1  clear pulse; timeout_flag  out  1  sticky; pending_count  out  4  CPU-visible outstanding reads.

Function
REQ-011 SHALL hold one registered command slot (cmd_valid, address, byteenable, writedata, is_read, is_write).
REQ-012 A CPU command SHALL be captured when cpu_read|cpu_write and cpu_waitrequest=0; cpu_read and cpu_write both high is illegal and SHALL be treated as a read.
REQ-013 cpu_waitrequest SHALL equal cmd_valid & !issue, where issue = (xb_read|xb_write) & !xb_waitrequest; this permits back-to-back capture.
REQ-014 xb_write SHALL equal cmd_valid & is_write; writes are posted with no response.
REQ-015 xb_read SHALL equal cmd_valid & is_read & (pending+dropped < MAX_PENDING).
REQ-016 xb_* command fields SHALL be driven only from the slot and SHALL stay stable while xb_waitrequest=1.
REQ-017 pending SHALL increment on an issued read and decrement on a CPU-visible response; simultaneous increment and decrement SHALL leave it unchanged.
REQ-018 Watchdog timer SHALL count while pending>0 and SHALL clear on any xb_readdatavalid or when pending=0.
REQ-019 When the timer reaches TIMEOUT_CYCLES-1 with no xb_readdatavalid in that cycle, the block SHALL synthesize a response (ERR_DATA), decrement pending, increment dropped, and set timeout_flag.
REQ-020 xb_readdatavalid with dropped>0 SHALL be discarded and SHALL decrement dropped; with dropped=0 and pending>0 it SHALL be forwarded.
REQ-021 xb_readdatavalid with pending=0 and dropped=0 (stray) SHALL be discarded.
REQ-022 cpu_readdata/cpu_readdatavalid SHALL be registered: one cycle of latency after xb_readdatavalid or the timeout cycle.
REQ-023 A real response coincident with timeout SHALL take priority; no synthetic response is generated in that cycle.
REQ-024 timeout_flag set SHALL win over a simultaneous timeout_clr.
REQ-025 Counters SHALL never wrap; pending+dropped <= MAX_PENDING holds by construction.

Reset
REQ-026 On reset: cmd_valid, pending, dropped, timer, and timeout_flag SHALL be 0; cpu_readdatavalid, cpu_waitrequest, xb_read, xb_write SHALL be 0; data outputs SHALL be 0.
REQ-027 Responses for reads issued before a mid-operation reset SHALL be discarded as stray.

Structure
REQ-028 Package io_cmd_pipeline_pkg SHALL hold ERR_DATA default, address/data/byteenable widths, and counter width (clog2(MAX_PENDING+1)).
REQ-029 Sub-module io_read_watchdog SHALL own the timer and the pending/dropped counters and emit synth_resp and forward_resp.

Verification
REQ-030 Single write A=3, D=32'h12345678, xb_waitrequest=0 -> xb_write one cycle later, no cpu_readdatavalid.
REQ-031 Read A=5, xb returns 32'hCAFE0001 after 10 cycles -> cpu_readdata=32'hCAFE0001 one cycle later; pending 1->0.
REQ-032 Issue 9 reads with no responses -> 8 issued, 9th held with cpu_waitrequest=1 until the first response.
REQ-033 Read with no response -> at cycle 1023 cpu_readdata=32'hDEADBEEF and timeout_flag=1; a late response at cycle 1100 is discarded with dropped 1->0.
REQ-034 Real response in the exact timeout cycle -> real data forwarded, timeout_flag stays 0.
REQ-035 Reset asserted with 3 reads outstanding -> all counters 0; subsequent responses discarded.
